gost_pipe_core: RTL and testbench
=================================

// Module: gost_pipe_core
// PURPOSE
//  Parametrised GOST R 34.12-2015 Magma (64-bit block, 256-bit key) cipher core; successor to the single-round-per-pass core.
//  Adds valid/ready streaming handshakes, a configurable number of rounds per clock, and a CTR (gamma) mode per GOST R 34.13-2015.
//  Sits between the SD data path and the block buffer; encrypts or decrypts one 64-bit block at a time.
// PARAMETERS
//  ROUNDS_PER_CYCLE  1  Magma rounds evaluated per clock; legal values 1, 2, 4, 8. Run length N = 32/ROUNDS_PER_CYCLE cycles.
//  ENABLE_CTR        1  1: CTR mode is available. 0: imode=2'b10 is treated as ECB encrypt and no counter register is built.
// PORTS
//  iclk      in   1    clock; all state changes on the rising edge
//  irst      in   1    reset; asynchronous, active-low
//  iinit     in   1    load iiv into the CTR counter; honoured only in IDLE
//  iiv       in   32   CTR IV; counter is loaded as {iiv, 32'h0}
//  imode     in   2    00 ECB encrypt, 01 ECB decrypt, 10 CTR, 11 reserved (treated as 00); sampled on accept
//  ikey      in   256  key K1..K8, K1=ikey[255:224]; sampled on accept
//  ivalid    in   1    input block valid
//  iblock    in   64   input block
//  oready    out  1    core can accept a block (1 only in IDLE)
//  ovalid    out  1    oblock valid
//  iready    in   1    downstream accepts oblock
//  oblock    out  64   result block
// BEHAVIOUR
//  Reset (irst=0, async): state=IDLE; oready=0 while in reset, then 1 from the first edge after release; ovalid=0; oblock=0; counter=0.
//   A reset mid-run discards the block in flight, with no output.
//  FSM states:
//   IDLE: oready=1. Accept when ivalid&oready: latch iblock (CTR: latch the counter value instead), ikey, imode; round index=0; go to RUN.
//    If iinit=1 on the same edge, the counter loads first and the accepted block uses the new counter.
//   RUN: each edge applies ROUNDS_PER_CYCLE rounds.
//    After edge N: apply the final half swap; go to DONE. ECB: oblock=result. CTR: oblock=latched iblock XOR E(counter); counter+=1 mod 2^64.
//   DONE: ovalid=1, oblock held stable. On iready=1: go to IDLE; ovalid=0 on the next cycle.
//    oready=0 in DONE, so there is no accept on the same edge. Throughput is 1 block per N+2 cycles.
//  Latency: the accept edge is E0; ovalid is high after edge E_N (N=32 for R=1, N=4 for R=8).
//  Round function: L'=R; R'=L ^ rotl11(S(R + K mod 2^32)).
//   S = the eight 4-bit S-boxes of GOST R 34.12-2015 (pi0 acts on nibble [3:0]).
//   Input split: L=blk[63:32], R=blk[31:0].
//  Key order:
//   Encrypt and CTR: rounds 0-23 use K1..K8 repeated; rounds 24-31 use K8..K1.
//   Decrypt: the exact reverse of the encrypt order.
//   The final output is {R,L} after round 32 (no swap on round 32).
//  iinit/iiv are ignored outside IDLE. The counter wraps 64'hFFFF_FFFF_FFFF_FFFF -> 0 silently.
//  Inputs are ignored while oready=0. ikey, imode and iblock may change freely after accept.
//  imode=01 in CTR context is plain ECB decrypt: CTR uses only the encrypt direction.
// TESTING
//  1 ECB enc: key ffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, block fedcba9876543210.
//    Required: oblock=4ee901e5c2d8ca3d; ovalid after exactly 32/R edges; run for R=1,2,4,8.
//  2 ECB dec: same key, block 4ee901e5c2d8ca3d, imode=01 -> oblock=fedcba9876543210.
//  3 CTR: iinit with iiv=12345678, then block 92def06b3c130a59, imode=10, same key.
//    Required: oblock=4e98110c97b7b93c; counter=1234567800000001 afterwards.
//  4 Backpressure: hold iready=0 for 10 cycles in DONE.
//    Required: ovalid and oblock stable, oready=0, ivalid pulses ignored; iready=1 -> IDLE; the next block is accepted.
//  5 Reset mid-run: drop irst at round 10, release it, send block fedcba9876543210 ECB.
//    Required: no stray ovalid; the correct result for the new block.
//  6 Wrap: iinit with iiv=ffffffff, then force the counter to all-ones; encrypt 2 CTR blocks.
//    Required: the second block uses counter 0000000000000000.

Source files
------------

// File: rtl/gost_pipe_core_if.sv
// Streaming handshake bundle for gost_pipe_core.
// The master side supplies the key, mode, counter IV and input blocks.
// The slave side (the core) returns result blocks under a valid/ready handshake.
interface gost_pipe_core_if;
   logic         iinit;
   logic [31:0]  iiv;
   logic [1:0]   imode;
   logic [255:0] ikey;
   logic         ivalid;
   logic [63:0]  iblock;
   logic         oready;
   logic         ovalid;
   logic         iready;
   logic [63:0]  oblock;

   modport master (
      output iinit, iiv, imode, ikey, ivalid, iblock, iready,
      input  oready, ovalid, oblock
   );

   modport slave (
      input  iinit, iiv, imode, ikey, ivalid, iblock, iready,
      output oready, ovalid, oblock
   );
endinterface

// File: rtl/gost_pipe_core.sv
// Magma (GOST R 34.12-2015) block cipher core, 64-bit block and 256-bit key.
// The core evaluates ROUNDS_PER_CYCLE rounds per clock and offers ECB encrypt,
// ECB decrypt and an optional CTR (gamma) mode.
// The flow is IDLE -> RUN (N cycles) -> DONE, where the result is held until the consumer takes it.
module gost_pipe_core #(
   parameter int ROUNDS_PER_CYCLE = 1,
   parameter bit ENABLE_CTR       = 1'b1
) (
   input  logic            iclk,
   input  logic            irst,
   gost_pipe_core_if.slave bus
);
   localparam logic [4:0] RSTEP = 5'(ROUNDS_PER_CYCLE);
   localparam logic [4:0] RLAST = 5'(32 - ROUNDS_PER_CYCLE);

   // S-boxes pi0..pi7. Entry x sits at bits [63-4x -: 4]. pi0 acts on nibble [3:0].
   localparam logic [63:0] SBOX [8] = '{
      64'hC462A5B9E8D703F1, 64'h68239A5C1E47BD0F,
      64'hB3582FADE174C960, 64'hC821D4F670A53E9B,
      64'h7F5A816D093EB42C, 64'h5DF692CAB78143E0,
      64'h8E25691CF4B0DA37, 64'h17ED05834FA69CB2
   };

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic [31:0] sbox32(input logic [31:0] x);
      logic [31:0] y;
      logic [3:0]  nib;
      y = 32'h0;
      for (int n = 0; n < 8; n++) begin
         nib = x[4*n +: 4];
         y[4*n +: 4] = SBOX[n][(15 - int'(nib)) * 4 +: 4];
      end
      return y;
   endfunction

   // One round: L' = R, R' = L ^ rotl11(S(R + K)).
   function automatic logic [63:0] magma_round(input logic [63:0] blk, input logic [31:0] k);
      logic [31:0] s;
      s = sbox32(blk[31:0] + k);
      return {blk[31:0], blk[63:32] ^ {s[20:0], s[31:21]}};
   endfunction

   // Encrypt uses K1..K8 x3 and then K8..K1. Decrypt is that sequence reversed.
   function automatic logic [2:0] key_idx(input logic [4:0] rnd, input logic dec);
      logic [2:0] idx;
      if (dec) begin
         if (rnd < 5'd8) idx = rnd[2:0];
         else            idx = ~rnd[2:0];
      end else begin
         if (rnd < 5'd24) idx = rnd[2:0];
         else             idx = ~rnd[2:0];
      end
      return idx;
   endfunction

   // K1 is the top word of the key.
   function automatic logic [31:0] key_word(input logic [255:0] key, input logic [2:0] idx);
      return key[(7 - int'(idx)) * 32 +: 32];
   endfunction

   state_t       state_q, state_d;
   logic [4:0]   rnd_q, rnd_d;
   logic [63:0]  blk_q, blk_d;
   logic [255:0] key_q, key_d;
   logic         dec_q, dec_d;
   logic         ctrm_q, ctrm_d;
   logic [63:0]  data_q, data_d;
   logic         oready_q, oready_d;
   logic         ovalid_q, ovalid_d;
   logic [63:0]  oblock_q, oblock_d;
   logic [63:0]  ctr_q, ctr_d;
   logic [63:0]  blk_t;
   logic [63:0]  fin_s;

   assign bus.oready = oready_q;
   assign bus.ovalid = ovalid_q;
   assign bus.oblock = oblock_q;

   // Unrolled round chain for this cycle, plus the final half swap applied at the end of the run.
   always_comb begin
      blk_t = blk_q;
      for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
         blk_t = magma_round(blk_t, key_word(key_q, key_idx(rnd_q + 5'(k), dec_q)));
      end
      fin_s = {blk_t[31:0], blk_t[63:32]};
   end

   // Next-state logic for the handshake FSM, the datapath registers and the counter.
   always_comb begin
      state_d  = state_q;
      rnd_d    = rnd_q;
      blk_d    = blk_q;
      key_d    = key_q;
      dec_d    = dec_q;
      ctrm_d   = ctrm_q;
      data_d   = data_q;
      oready_d = oready_q;
      ovalid_d = ovalid_q;
      oblock_d = oblock_q;
      ctr_d    = ctr_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.iinit) ctr_d = {bus.iiv, 32'h0};
            else           ctr_d = ctr_q;
            if (bus.ivalid && oready_q) begin
               state_d  = ST_RUN;
               rnd_d    = 5'd0;
               key_d    = bus.ikey;
               data_d   = bus.iblock;
               dec_d    = (bus.imode == 2'b01);
               ctrm_d   = ENABLE_CTR && (bus.imode == 2'b10);
               blk_d    = ctrm_d ? ctr_d : bus.iblock;
               oready_d = 1'b0;
            end else begin
               oready_d = 1'b1;
            end
         end
         ST_RUN: begin
            blk_d    = blk_t;
            rnd_d    = rnd_q + RSTEP;
            oready_d = 1'b0;
            if (rnd_q == RLAST) begin
               state_d  = ST_DONE;
               ovalid_d = 1'b1;
               oblock_d = ctrm_q ? (data_q ^ fin_s) : fin_s;
               if (ctrm_q) ctr_d = ctr_q + 64'd1;
               else        ctr_d = ctr_q;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_DONE: begin
            if (bus.iready) begin
               state_d  = ST_IDLE;
               ovalid_d = 1'b0;
               oready_d = 1'b1;
            end else begin
               state_d  = ST_DONE;
               oready_d = 1'b0;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            oready_d = 1'b0;
            ovalid_d = 1'b0;
         end
      endcase
   end

   // FSM state, datapath and registered outputs.
   always_ff @(posedge iclk or negedge irst) begin
      if (!irst) begin
         state_q  <= ST_IDLE;
         rnd_q    <= 5'd0;
         blk_q    <= 64'h0;
         key_q    <= 256'h0;
         dec_q    <= 1'b0;
         ctrm_q   <= 1'b0;
         data_q   <= 64'h0;
         oready_q <= 1'b0;
         ovalid_q <= 1'b0;
         oblock_q <= 64'h0;
      end else begin
         state_q  <= state_d;
         rnd_q    <= rnd_d;
         blk_q    <= blk_d;
         key_q    <= key_d;
         dec_q    <= dec_d;
         ctrm_q   <= ctrm_d;
         data_q   <= data_d;
         oready_q <= oready_d;
         ovalid_q <= ovalid_d;
         oblock_q <= oblock_d;
      end
   end

   if (ENABLE_CTR) begin : g_ctr
      // CTR counter register. It wraps silently at 2^64.
      always_ff @(posedge iclk or negedge irst) begin
         if (!irst) ctr_q <= 64'h0;
         else       ctr_q <= ctr_d;
      end
   end else begin : g_no_ctr
      assign ctr_q = 64'h0;
   end
endmodule

// File: tb/tb_gost_pipe_core.sv
// Directed bench for gost_pipe_core.
// It covers reset, ECB encrypt and decrypt, CTR, backpressure, a mid-run reset and counter wrap.
// Extra instances with 2, 4 and 8 rounds per cycle share the stimulus so the latency scaling can be checked.
module tb_gost_pipe_core;
   localparam logic [255:0] KEY = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
   localparam logic [63:0]  PT  = 64'hfedcba9876543210;
   localparam logic [63:0]  CT  = 64'h4ee901e5c2d8ca3d;

   localparam logic [3:0] PI [8][16] = '{
      '{4'hC,4'h4,4'h6,4'h2,4'hA,4'h5,4'hB,4'h9,4'hE,4'h8,4'hD,4'h7,4'h0,4'h3,4'hF,4'h1},
      '{4'h6,4'h8,4'h2,4'h3,4'h9,4'hA,4'h5,4'hC,4'h1,4'hE,4'h4,4'h7,4'hB,4'hD,4'h0,4'hF},
      '{4'hB,4'h3,4'h5,4'h8,4'h2,4'hF,4'hA,4'hD,4'hE,4'h1,4'h7,4'h4,4'hC,4'h9,4'h6,4'h0},
      '{4'hC,4'h8,4'h2,4'h1,4'hD,4'h4,4'hF,4'h6,4'h7,4'h0,4'hA,4'h5,4'h3,4'hE,4'h9,4'hB},
      '{4'h7,4'hF,4'h5,4'hA,4'h8,4'h1,4'h6,4'hD,4'h0,4'h9,4'h3,4'hE,4'hB,4'h4,4'h2,4'hC},
      '{4'h5,4'hD,4'hF,4'h6,4'h9,4'h2,4'hC,4'hA,4'hB,4'h7,4'h8,4'h1,4'h4,4'h3,4'hE,4'h0},
      '{4'h8,4'hE,4'h2,4'h5,4'h6,4'h9,4'h1,4'hC,4'hF,4'h4,4'hB,4'h0,4'hD,4'hA,4'h3,4'h7},
      '{4'h1,4'h7,4'hE,4'hD,4'h0,4'h5,4'h8,4'h3,4'h4,4'hF,4'hA,4'h6,4'h9,4'hC,4'hB,4'h2}
   };

   logic iclk;
   logic irst;
   int   vec_cnt;
   int   err_cnt;

   gost_pipe_core_if bus();

   gost_pipe_core #(.ROUNDS_PER_CYCLE(1), .ENABLE_CTR(1'b1)) dut (
      .iclk (iclk),
      .irst (irst),
      .bus  (bus)
   );

   logic        x_ovalid [1:3];
   logic [63:0] x_oblock [1:3];

   for (genvar g = 1; g < 4; g++) begin : g_x
      gost_pipe_core_if xb();
      assign xb.iinit  = bus.iinit;
      assign xb.iiv    = bus.iiv;
      assign xb.imode  = bus.imode;
      assign xb.ikey   = bus.ikey;
      assign xb.ivalid = bus.ivalid;
      assign xb.iblock = bus.iblock;
      assign xb.iready = bus.iready;
      gost_pipe_core #(.ROUNDS_PER_CYCLE(1 << g), .ENABLE_CTR(1'b1)) xdut (
         .iclk (iclk),
         .irst (irst),
         .bus  (xb)
      );
      assign x_ovalid[g] = xb.ovalid;
      assign x_oblock[g] = xb.oblock;
   end

   initial iclk = 1'b0;
   always #5 iclk = ~iclk;

   // Straight-line Magma encrypt reference, used where no published vector exists.
   function automatic logic [63:0] ref_enc(input logic [255:0] key, input logic [63:0] blk);
      logic [31:0] k [8];
      logic [31:0] a0, a1, t, g;
      int          ki;
      for (int j = 0; j < 8; j++) k[j] = key[255 - 32*j -: 32];
      a1 = blk[63:32];
      a0 = blk[31:0];
      for (int i = 0; i < 32; i++) begin
         ki = (i < 24) ? (i % 8) : (31 - i);
         t  = a0 + k[ki];
         g  = 32'h0;
         for (int n = 0; n < 8; n++) g[4*n +: 4] = PI[n][t[4*n +: 4]];
         g  = (g << 11) | (g >> 21);
         t  = a1 ^ g;
         a1 = a0;
         a0 = t;
      end
      return {a0, a1};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %h, want %h", tag, got, exp);
      end
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge iclk);
      while (bus.oready !== 1'b1 && n < 100) begin
         @(negedge iclk);
         n++;
      end
      if (n >= 100) chk("oready_timeout", {63'd0, bus.oready}, 64'd1);
   endtask

   // Offer one block, then count the edges from the accept until ovalid.
   task automatic send(input logic [63:0] blk, input logic [1:0] mode, output int lat);
      wait_ready();
      bus.iblock = blk;
      bus.imode  = mode;
      bus.ivalid = 1'b1;
      @(posedge iclk); #1;
      bus.ivalid = 1'b0;
      bus.iinit  = 1'b0;
      bus.iblock = 64'h0;
      bus.imode  = 2'b11;
      lat = 0;
      while (bus.ovalid !== 1'b1 && lat < 64) begin
         @(posedge iclk); #1;
         lat++;
      end
   endtask

   task automatic recv(input string tag, input logic [63:0] exp);
      chk(tag, bus.oblock, exp);
      bus.iready = 1'b1;
      @(posedge iclk); #1;
      bus.iready = 1'b0;
      chk({tag, "_ovalid_drop"}, {63'd0, bus.ovalid}, 64'd0);
   endtask

   initial begin
      int          lat;
      int          xlat [1:3];
      logic        stray;
      logic [63:0] e1;
      logic [63:0] e2;
      vec_cnt    = 0;
      err_cnt    = 0;
      irst       = 1'b0;
      bus.iinit  = 1'b0;
      bus.iiv    = 32'h0;
      bus.imode  = 2'b00;
      bus.ikey   = KEY;
      bus.ivalid = 1'b0;
      bus.iblock = 64'h0;
      bus.iready = 1'b0;

      // reset state
      repeat (3) @(negedge iclk);
      chk("rst_oready", {63'd0, bus.oready}, 64'd0);
      chk("rst_ovalid", {63'd0, bus.ovalid}, 64'd0);
      chk("rst_oblock", bus.oblock, 64'h0);
      chk("rst_ctr", dut.ctr_q, 64'h0);
      irst = 1'b1;
      #1;
      chk("oready_before_edge", {63'd0, bus.oready}, 64'd0);
      @(posedge iclk); #1;
      chk("oready_after_release", {63'd0, bus.oready}, 64'd1);

      // ECB encrypt at R = 1, 2, 4 and 8 in parallel
      @(negedge iclk);
      bus.iblock = PT;
      bus.imode  = 2'b00;
      bus.ivalid = 1'b1;
      @(posedge iclk); #1;
      bus.ivalid = 1'b0;
      bus.iblock = 64'h0;
      lat = 0;
      for (int g = 1; g < 4; g++) xlat[g] = 0;
      for (int e = 1; e <= 40; e++) begin
         @(posedge iclk); #1;
         if (lat == 0 && bus.ovalid === 1'b1) lat = e;
         for (int g = 1; g < 4; g++) if (xlat[g] == 0 && x_ovalid[g] === 1'b1) xlat[g] = e;
      end
      chk("ecb_lat_r1", 64'(lat), 64'd32);
      for (int g = 1; g < 4; g++) begin
         chk($sformatf("ecb_lat_r%0d", 1 << g), 64'(xlat[g]), 64'(32 >> g));
         chk($sformatf("ecb_blk_r%0d", 1 << g), x_oblock[g], CT);
      end
      chk("done_oready", {63'd0, bus.oready}, 64'd0);
      recv("ecb_enc_r1", CT);
      chk("idle_oready", {63'd0, bus.oready}, 64'd1);

      // ECB decrypt
      send(CT, 2'b01, lat);
      chk("dec_lat", 64'(lat), 64'd32);
      recv("ecb_dec", PT);

      // CTR, with the IV loaded on the accept edge itself
      bus.iinit = 1'b1;
      bus.iiv   = 32'h12345678;
      send(64'h92def06b3c130a59, 2'b10, lat);
      recv("ctr_blk", 64'h4e98110c97b7b93c);
      chk("ctr_after", dut.ctr_q, 64'h1234567800000001);

      // Backpressure in DONE, with input pulses that must be ignored
      send(PT, 2'b00, lat);
      for (int i = 0; i < 10; i++) begin
         @(negedge iclk);
         bus.ivalid = i[0];
         bus.iblock = 64'(i) * 64'h0101010101010101;
         bus.iinit  = 1'b1;
         bus.iiv    = 32'hdeadbeef;
         @(posedge iclk); #1;
         chk("bp_ovalid", {63'd0, bus.ovalid}, 64'd1);
         chk("bp_oblock", bus.oblock, CT);
         chk("bp_oready", {63'd0, bus.oready}, 64'd0);
      end
      bus.ivalid = 1'b0;
      bus.iinit  = 1'b0;
      recv("bp_release", CT);
      chk("bp_idle_oready", {63'd0, bus.oready}, 64'd1);
      chk("bp_ctr_kept", dut.ctr_q, 64'h1234567800000001);
      send(CT, 2'b01, lat);
      recv("bp_next", PT);

      // Reset in the middle of a run
      wait_ready();
      bus.iblock = 64'h0123456789abcdef;
      bus.imode  = 2'b00;
      bus.ivalid = 1'b1;
      @(posedge iclk); #1;
      bus.ivalid = 1'b0;
      repeat (10) @(posedge iclk);
      #1;
      irst = 1'b0;
      #1;
      chk("midrst_ovalid", {63'd0, bus.ovalid}, 64'd0);
      chk("midrst_ctr", dut.ctr_q, 64'h0);
      @(negedge iclk);
      irst  = 1'b1;
      stray = 1'b0;
      for (int e = 0; e < 40; e++) begin
         @(posedge iclk); #1;
         if (bus.ovalid !== 1'b0) stray = 1'b1;
      end
      chk("no_stray_ovalid", {63'd0, stray}, 64'd0);
      send(PT, 2'b00, lat);
      chk("post_rst_lat", 64'(lat), 64'd32);
      recv("post_rst_blk", CT);

      // Counter wrap across all-ones
      bus.iinit = 1'b1;
      bus.iiv   = 32'hffffffff;
      @(posedge iclk); #1;
      bus.iinit = 1'b0;
      chk("wrap_iv_load", dut.ctr_q, 64'hffffffff00000000);
      @(negedge iclk);
      force dut.ctr_q = 64'hffffffffffffffff;
      @(negedge iclk);
      release dut.ctr_q;
      e1 = ref_enc(KEY, 64'hffffffffffffffff) ^ 64'h1111111111111111;
      e2 = ref_enc(KEY, 64'h0) ^ 64'h0123456789abcdef;
      send(64'h1111111111111111, 2'b10, lat);
      recv("wrap_blk1", e1);
      chk("wrap_ctr_zero", dut.ctr_q, 64'h0);
      send(64'h0123456789abcdef, 2'b10, lat);
      recv("wrap_blk2", e2);
      chk("wrap_ctr_one", dut.ctr_q, 64'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end
endmodule
